// File: rtl/pbit_network_engine.sv
// pbit_network_engine
//   Probabilistic-bit (p-bit) network with runtime-writable bias vector h and
//   coupling matrix J. P-bits are colour-grouped (p-bit i is in group
//   i mod NUM_GROUPS) and updated one group at a time. Each group takes
//   GROUP_CYCLES cycles. After the last group of a sweep, the output slice of
//   the network is handed to the consumer through a valid/ready handshake.
//
// Ports
//   clk           clock
//   reset_n       synchronous active-low reset
//   run           1 = keep sweeping, 0 = stop at the next group boundary
//   beta          unsigned inverse temperature, FRAC fractional bits
//   clamp_en      force clampable p-bits through their effective bias
//   clamp_val     per clampable p-bit: 1 -> +max bias, 0 -> min bias
//   cfg_we        config write strobe (honoured only while idle)
//   cfg_sel       0 = write h[cfg_row], 1 = write J[cfg_row][cfg_col]
//   cfg_row       row index
//   cfg_col       column index
//   cfg_data      signed value to write
//   busy          engine not idle
//   sample_valid  snapshot available
//   sample_ready  consumer accepts snapshot
//   sample_data   m[OUT_BASE +: NUM_OUT] captured at sweep end
//   sweep_count   completed sweeps since reset (wraps)
module pbit_network_engine #(
  parameter int          NUM_PBITS    = 91,
  parameter int          W_WIDTH      = 8,
  parameter int          FRAC         = 3,
  parameter int          NUM_GROUPS   = 5,
  parameter int          GROUP_CYCLES = 4,
  parameter int          NUM_CLAMP    = 8,
  parameter int          CLAMP_BASE   = 83,
  parameter int          NUM_OUT      = 8,
  parameter int          OUT_BASE     = 83,
  parameter logic [31:0] SEED_BASE    = 32'h1234_5678
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic [W_WIDTH-1:0]           beta,
  input  logic                         clamp_en,
  input  logic [NUM_CLAMP-1:0]         clamp_val,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic [$clog2(NUM_PBITS)-1:0] cfg_row,
  input  logic [$clog2(NUM_PBITS)-1:0] cfg_col,
  input  logic signed [W_WIDTH-1:0]    cfg_data,
  output logic                         busy,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [NUM_OUT-1:0]           sample_data,
  output logic [31:0]                  sweep_count
);

  localparam int IDX_W   = $clog2(NUM_PBITS);
  localparam int ACC_W   = W_WIDTH + IDX_W;
  localparam int SLOTS   = (NUM_PBITS + NUM_GROUPS - 1) / NUM_GROUPS;
  localparam int PH_W    = $clog2(GROUP_CYCLES);
  localparam int GRP_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int SAT_MAX = 2 ** (W_WIDTH - 1) - 1;
  localparam int SAT_MIN = -(2 ** (W_WIDTH - 1));

  localparam logic signed [W_WIDTH-1:0] W_MAX = W_WIDTH'(SAT_MAX);
  localparam logic signed [W_WIDTH-1:0] W_MIN = W_WIDTH'(SAT_MIN);
  localparam logic [PH_W-1:0]           PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]           PH_LAST  = PH_W'(GROUP_CYCLES - 1);
  localparam logic [GRP_W-1:0]          GRP_LAST = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_HOLD} state_t;

  // Clip an integer result into the signed W_WIDTH range.
  function automatic logic signed [W_WIDTH-1:0] sat_w(input int v);
    if (v > SAT_MAX)      return W_MAX;
    else if (v < SAT_MIN) return W_MIN;
    else                  return W_WIDTH'(v);
  endfunction

  // Scale a field by beta (unsigned, FRAC fractional bits) and saturate.
  function automatic logic signed [W_WIDTH-1:0] scale_sat(
    input logic signed [W_WIDTH-1:0] f,
    input logic [W_WIDTH-1:0]        b
  );
    return sat_w((int'(f) * int'(b)) >>> FRAC);
  endfunction

  function automatic logic [31:0] seed_of(input int i);
    logic [31:0] s;
    s = SEED_BASE ^ (32'(i) * 32'h9E37_79B9);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  // Galois right-shift form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  state_t                      r_state;
  logic [GRP_W-1:0]            r_group;
  logic [PH_W-1:0]             r_phase;
  logic [NUM_PBITS-1:0]        r_m;
  logic [31:0]                 r_lfsr [NUM_PBITS];
  logic signed [W_WIDTH-1:0]   r_h    [NUM_PBITS];
  logic signed [W_WIDTH-1:0]   r_j    [NUM_PBITS][NUM_PBITS];
  logic                        r_valid;
  logic [NUM_OUT-1:0]          r_data;
  logic [31:0]                 r_sweep_cnt;
  logic signed [W_WIDTH-1:0]   r_field_p0 [SLOTS];

  logic                        w_slot_ok  [SLOTS];
  logic [IDX_W-1:0]            w_slot_idx [SLOTS];
  logic signed [ACC_W-1:0]     w_acc      [SLOTS];
  logic signed [W_WIDTH-1:0]   w_heff     [SLOTS];
  logic signed [W_WIDTH-1:0]   w_field    [SLOTS];
  logic signed [W_WIDTH-1:0]   w_inp      [SLOTS];
  logic [NUM_PBITS-1:0]        w_m_next;

  assign busy         = (r_state != S_IDLE);
  assign sample_valid = r_valid;
  assign sample_data  = r_data;
  assign sweep_count  = r_sweep_cnt;

  // Stage p0: local field of every p-bit in the current group.
  // Slot k serves p-bit group + k*NUM_GROUPS; trailing slots may be empty.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      w_slot_ok[k]  = (int'(r_group) + k * NUM_GROUPS) < NUM_PBITS;
      w_slot_idx[k] = w_slot_ok[k] ? IDX_W'(int'(r_group) + k * NUM_GROUPS) : '0;
      w_acc[k]      = '0;
      for (int j = 0; j < NUM_PBITS; j++) begin
        if (r_m[j]) w_acc[k] = w_acc[k] + ACC_W'(r_j[w_slot_idx[k]][j]);
      end
      w_heff[k] = r_h[w_slot_idx[k]];
      for (int c = 0; c < NUM_CLAMP; c++) begin
        if (clamp_en && w_slot_ok[k] && (int'(w_slot_idx[k]) == CLAMP_BASE + c))
          w_heff[k] = clamp_val[c] ? W_MAX : W_MIN;
      end
      w_field[k] = sat_w(int'(w_acc[k]) + int'(w_heff[k]));
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_SWEEP && r_phase == '0) begin
      for (int k = 0; k < SLOTS; k++) r_field_p0[k] <= w_field[k];
    end
  end

  // Stage p1: temperature scaling of the registered field and stochastic
  // decision against the p-bit's own LFSR, committed on the phase-1 edge.
  always_comb begin
    w_m_next = r_m;
    for (int k = 0; k < SLOTS; k++) begin
      w_inp[k] = scale_sat(r_field_p0[k], beta);
      if (r_state == S_SWEEP && r_phase == PH_ONE && w_slot_ok[k])
        w_m_next[w_slot_idx[k]] =
          (w_inp[k] >= $signed(r_lfsr[w_slot_idx[k]][31 -: W_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_group     <= '0;
      r_phase     <= '0;
      r_m         <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_sweep_cnt <= '0;
      for (int i = 0; i < NUM_PBITS; i++) begin
        r_h[i]    <= '0;
        r_lfsr[i] <= seed_of(i);
        for (int j = 0; j < NUM_PBITS; j++) r_j[i][j] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we && (int'(cfg_row) < NUM_PBITS)) begin
            if (!cfg_sel)
              r_h[cfg_row] <= cfg_data;
            else if (int'(cfg_col) < NUM_PBITS)
              r_j[cfg_row][cfg_col] <= cfg_data;
          end
          if (run) r_state <= S_SWEEP;
        end
        S_SWEEP: begin
          r_m <= w_m_next;
          if (r_phase == PH_ONE) begin
            for (int k = 0; k < SLOTS; k++) begin
              if (w_slot_ok[k]) r_lfsr[w_slot_idx[k]] <= lfsr_step(r_lfsr[w_slot_idx[k]]);
            end
          end
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            if (r_group == GRP_LAST) begin
              // w_m_next so the snapshot includes a same-edge update when
              // GROUP_CYCLES is 2.
              r_sweep_cnt <= r_sweep_cnt + 32'd1;
              r_data      <= w_m_next[OUT_BASE +: NUM_OUT];
              r_valid     <= 1'b1;
              r_state     <= S_HOLD;
            end else if (!run) begin
              // Group is kept; the next run resumes from this group.
              r_state <= S_IDLE;
            end else begin
              r_group <= r_group + GRP_W'(1);
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        S_HOLD: begin
          if (sample_ready) begin
            r_valid <= 1'b0;
            r_group <= '0;
            r_state <= run ? S_SWEEP : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_network_engine.sv
module tb_pbit_network_engine;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run;
  logic [7:0]        beta;
  logic              clamp_en;
  logic [7:0]        clamp_val;
  logic              cfg_we;
  logic              cfg_sel;
  logic [6:0]        cfg_row;
  logic [6:0]        cfg_col;
  logic signed [7:0] cfg_data;
  logic              busy;
  logic              sample_valid;
  logic              sample_ready;
  logic [7:0]        sample_data;
  logic [31:0]       sweep_count;

  pbit_network_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .beta         (beta),
    .clamp_en     (clamp_en),
    .clamp_val    (clamp_val),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_row      (cfg_row),
    .cfg_col      (cfg_col),
    .cfg_data     (cfg_data),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .sweep_count  (sweep_count)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          last_vcyc = 0;
  int          ones = 0;
  logic [31:0] exp_cnt = 0;
  logic [7:0]  last_data = 0;
  // Reference model of the eight output p-bits (indices 83..90).
  logic [31:0] mlfsr [8];
  int          mfield [8];
  int          mbeta = 8;

  function automatic logic [31:0] m_seed(input int i);
    logic [31:0] s;
    s = 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic m_bit(input int field, input int b, input logic [31:0] l);
    int iv;
    int r;
    iv = (field * b) >>> 3;
    if (iv > 127) iv = 127;
    else if (iv < -128) iv = -128;
    r = int'($signed(l[31:24]));
    return iv >= r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reseed();
    for (int k = 0; k < 8; k++) mlfsr[k] = m_seed(83 + k);
  endtask

  task automatic model_next(output logic [7:0] e);
    for (int k = 0; k < 8; k++) begin
      e[k] = m_bit(mfield[k], mbeta, mlfsr[k]);
      mlfsr[k] = m_step(mlfsr[k]);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    cfg_we  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    model_reseed();
    exp_cnt = 0;
  endtask

  task automatic cfg_write(input logic sel, input int row, input int col, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_row  = 7'(row);
    cfg_col  = 7'(col);
    cfg_data = 8'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      tick();
      n++;
      if (sample_valid) got = 1'b1;
    end
  endtask

  // Period is counted from last_vcyc: the edge that samples run (or the
  // handshake) plus NUM_GROUPS*GROUP_CYCLES = 20 sweep edges -> 21 ticks.
  task automatic check_sample(input string tag, input bit chk_lat);
    bit         got;
    logic [7:0] e;
    wait_valid(got);
    chk({tag, " valid"}, 64'(got), 64'd1);
    if (got) begin
      if (chk_lat) chk({tag, " period"}, 64'(cyc - last_vcyc), 64'd21);
      model_next(e);
      chk({tag, " data"}, 64'(sample_data), 64'(e));
      exp_cnt = exp_cnt + 32'd1;
      chk({tag, " count"}, 64'(sweep_count), 64'(exp_cnt));
      last_vcyc = cyc;
      last_data = sample_data;
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    run          = 1'b0;
    beta         = 8'd8;
    clamp_en     = 1'b0;
    clamp_val    = 8'h00;
    cfg_we       = 1'b0;
    cfg_sel      = 1'b0;
    cfg_row      = 7'd0;
    cfg_col      = 7'd0;
    cfg_data     = 8'sd0;
    sample_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst valid", 64'(sample_valid), 64'd0);
    chk("rst data", 64'(sample_data), 64'd0);
    chk("rst count", 64'(sweep_count), 64'd0);

    // Unbiased network, beta = 1.0: m = (0 >= r) for every sweep
    beta  = 8'd8;
    mbeta = 8;
    for (int k = 0; k < 8; k++) mfield[k] = 0;
    sample_ready = 1'b1;
    run = 1'b1;
    last_vcyc = cyc;
    for (int s = 0; s < 1000; s++) begin
      check_sample("rand", 1'b1);
      ones += $countones(sample_data);
      if (s == 4) begin
        tick();
        chk("busy in sweep", 64'(busy), 64'd1);
        cfg_write(1'b0, 83, 0, 127);
      end
    end
    chk("bit frequency", 64'((ones >= 3600) && (ones <= 4400)), 64'd1);

    // Backpressure: 50 stalled cycles in HOLD, with an ignored config write
    tick();
    sample_ready = 1'b0;
    check_sample("stall", 1'b1);
    for (int t = 0; t < 50; t++) begin
      if (t == 10) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 7'd85; cfg_data = 8'sd127;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      chk("stall data", 64'(sample_data), 64'(last_data));
      chk("stall valid", 64'(sample_valid), 64'd1);
      chk("stall count", 64'(sweep_count), 64'(exp_cnt));
    end
    cfg_we = 1'b0;
    sample_ready = 1'b1;
    tick();
    chk("handshake drop", 64'(sample_valid), 64'd0);
    chk("handshake count", 64'(sweep_count), 64'(exp_cnt));
    last_vcyc = cyc - 1;
    check_sample("post stall", 1'b1);

    // Reset while holding a sample
    tick();
    sample_ready = 1'b0;
    check_sample("pre reset", 1'b1);
    tick();
    tick();
    reset_n = 1'b0;
    run = 1'b0;
    tick();
    chk("hold rst valid", 64'(sample_valid), 64'd0);
    chk("hold rst count", 64'(sweep_count), 64'd0);
    chk("hold rst busy", 64'(busy), 64'd0);
    chk("hold rst data", 64'(sample_data), 64'd0);
    reset_n = 1'b1;
    sample_ready = 1'b1;

    // Strong positive then strong negative output bias
    do_reset();
    for (int k = 0; k < 8; k++) cfg_write(1'b0, 83 + k, 0, 127);
    for (int k = 0; k < 8; k++) mfield[k] = 127;
    beta = 8'd8;
    mbeta = 8;
    run = 1'b1;
    last_vcyc = cyc;
    for (int s = 0; s < 4; s++) check_sample("h max", 1'b1);
    chk("h max value", 64'(sample_data), 64'hFF);
    run = 1'b0;
    tick();
    chk("stopped busy", 64'(busy), 64'd0);
    for (int k = 0; k < 8; k++) cfg_write(1'b0, 83 + k, 0, -128);
    for (int k = 0; k < 8; k++) mfield[k] = -128;
    run = 1'b1;
    last_vcyc = cyc;
    for (int s = 0; s < 4; s++) check_sample("h min", 1'b1);

    // Clamping, then release
    do_reset();
    clamp_val = 8'b1010_0101;
    clamp_en  = 1'b1;
    for (int k = 0; k < 8; k++) mfield[k] = clamp_val[k] ? 127 : -128;
    run = 1'b1;
    last_vcyc = cyc;
    for (int s = 0; s < 4; s++) check_sample("clamp", 1'b1);
    clamp_en = 1'b0;
    for (int k = 0; k < 8; k++) mfield[k] = 0;
    for (int s = 0; s < 8; s++) check_sample("unclamp", 1'b1);

    // Field saturation: 83 active couplings of +127 into p-bit 83, beta = 2.0
    do_reset();
    for (int i = 0; i < 83; i++) cfg_write(1'b0, i, 0, 127);
    for (int j = 0; j < 83; j++) cfg_write(1'b1, 83, j, 127);
    cfg_write(1'b0, 83, 0, -128);
    cfg_write(1'b0, 100, 0, 127);
    beta  = 8'd16;
    mbeta = 16;
    for (int k = 0; k < 8; k++) mfield[k] = 0;
    mfield[0] = 127;
    run = 1'b1;
    last_vcyc = cyc;
    for (int s = 0; s < 4; s++) check_sample("saturate", 1'b1);
    chk("saturate bit", 64'(sample_data[0]), 64'd1);

    run = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
